// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer: pulls words from a show-ahead-less FIFO (data valid the
// cycle after the read strobe) and sends each as an async serial frame:
// one start bit (0), DATA_WIDTH data bits LSB first, one stop bit (1).
// Every bit is held for CLKS_PER_BIT clocks. All outputs except o_Busy are
// registered so the line and the FIFO strobe are glitch-free.
module fifo_tx_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Tx_en,
  input  logic                  i_Empty,
  input  logic [DATA_WIDTH-1:0] i_Data,
  output logic                  o_R_en,
  output logic                  o_Serial,
  output logic                  o_Busy,
  output logic                  o_Done
);

  // Counter widths; guarded so degenerate parameters never give zero-width vectors.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      baud;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  // Low for the first edge after reset release, so IDLE cannot issue a read
  // until the second rising edge.
  logic                  armed;

  assign o_Busy = (state != IDLE);

  // Frame sequencer: state, counters, shift register and registered outputs.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state    <= IDLE;
      armed    <= 1'b0;
      baud     <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      o_Serial <= 1'b1;
      o_R_en   <= 1'b0;
      o_Done   <= 1'b0;
    end else begin
      armed  <= 1'b1;
      o_R_en <= 1'b0;
      o_Done <= 1'b0;
      case (state)
        IDLE: begin
          o_Serial <= 1'b1;
          baud     <= '0;
          if (armed && i_Tx_en && !i_Empty) begin
            state  <= READ;
            o_R_en <= 1'b1;
          end
        end
        // Strobe is already high for this cycle; FIFO answers next cycle.
        READ: begin
          state <= WAIT;
        end
        // i_Data is valid now; load it and drop the line for the start bit.
        WAIT: begin
          shreg    <= i_Data;
          baud     <= '0;
          o_Serial <= 1'b0;
          state    <= START;
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud     <= '0;
            bit_idx  <= '0;
            o_Serial <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_idx == BIT_LAST) begin
              o_Serial <= 1'b1;
              state    <= STOP;
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              o_Serial <= shreg[0];
              shreg    <= shreg >> 1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        // Done is raised one cycle early so its register lands on the last
        // stop cycle; the exit decision re-checks enable and empty.
        STOP: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (i_Tx_en && !i_Empty) begin
              state  <= READ;
              o_R_en <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
            if (baud == BAUD_PRE) o_Done <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          o_Serial <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Directed bench for fifo_tx_serializer: 8-bit/4-clock instance for the main
// scenarios, 16-bit/2-clock instance for the parameter sweep. Each DUT reads
// from a small FIFO model with one-cycle read latency.
module tb_fifo_tx_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- DUT A: 8 data bits, 4 clocks per bit
  logic       tx_en_a = 1'b0;
  logic       empty_a;
  logic [7:0] data_a = '0;
  logic       r_en_a, serial_a, busy_a, done_a;
  logic [7:0] mem_a [0:15];
  logic [3:0] wp_a = '0, rp_a = '0;
  int         ren_a = 0;
  bit         uflow_a = 1'b0;

  assign empty_a = (wp_a == rp_a);

  fifo_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Tx_en(tx_en_a), .i_Empty(empty_a),
    .i_Data(data_a), .o_R_en(r_en_a), .o_Serial(serial_a),
    .o_Busy(busy_a), .o_Done(done_a)
  );

  always @(posedge clk) begin
    if (r_en_a === 1'b1) begin
      if (wp_a == rp_a) uflow_a <= 1'b1;
      data_a <= mem_a[rp_a];
      rp_a   <= rp_a + 4'd1;
    end
  end
  always @(negedge clk) if (r_en_a === 1'b1) ren_a <= ren_a + 1;

  // ---------------- DUT B: 16 data bits, 2 clocks per bit
  logic        tx_en_b = 1'b0;
  logic        empty_b;
  logic [15:0] data_b = '0;
  logic        r_en_b, serial_b, busy_b, done_b;
  logic [15:0] mem_b [0:15];
  logic [3:0]  wp_b = '0, rp_b = '0;
  int          ren_b = 0;

  assign empty_b = (wp_b == rp_b);

  fifo_tx_serializer #(.DATA_WIDTH(16), .CLKS_PER_BIT(2)) u_dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Tx_en(tx_en_b), .i_Empty(empty_b),
    .i_Data(data_b), .o_R_en(r_en_b), .o_Serial(serial_b),
    .o_Busy(busy_b), .o_Done(done_b)
  );

  always @(posedge clk) begin
    if (r_en_b === 1'b1) begin
      data_b <= mem_b[rp_b];
      rp_b   <= rp_b + 4'd1;
    end
  end
  always @(negedge clk) if (r_en_b === 1'b1) ren_b <= ren_b + 1;

  // ---------------- helpers (stimulus / bookkeeping only)
  task automatic push_a(input logic [7:0] v);
    mem_a[wp_a] = v;
    wp_a = wp_a + 4'd1;
  endtask

  task automatic push_b(input logic [15:0] v);
    mem_b[wp_b] = v;
    wp_b = wp_b + 4'd1;
  endtask

  // Count of samples that disagree with the expected bit sequence.
  function automatic int frame_err(input logic [63:0] ser, input logic [17:0] exp_bits,
                                   input int nbits, input int cpb);
    int e = 0;
    for (int i = 0; i < nbits * cpb; i++) if (ser[i] !== exp_bits[i / cpb]) e++;
    return e;
  endfunction

  // Count of samples where done differs from "high only on the last cycle".
  function automatic int done_err(input logic [63:0] dn, input int len);
    int e = 0;
    for (int i = 0; i < len; i++) if (dn[i] !== ((i == len - 1) ? 1'b1 : 1'b0)) e++;
    return e;
  endfunction

  // Called at a negedge; returns at the first negedge showing the start bit.
  task automatic wait_start_a(output int waited);
    bit found = 1'b0;
    waited = 0;
    while (!found && waited < 300) begin
      if (serial_a === 1'b0) found = 1'b1;
      else begin @(negedge clk); waited++; end
    end
    if (!found) begin
      n_chk++; n_fail++;
      $display("FAIL start_timeout_a: no start bit within %0d cycles", waited);
    end
  endtask

  task automatic wait_start_b(output int waited);
    bit found = 1'b0;
    waited = 0;
    while (!found && waited < 300) begin
      if (serial_b === 1'b0) found = 1'b1;
      else begin @(negedge clk); waited++; end
    end
    if (!found) begin
      n_chk++; n_fail++;
      $display("FAIL start_timeout_b: no start bit within %0d cycles", waited);
    end
  endtask

  // Records n cycles of line/done/busy; optional enable drop at sample drop_at.
  task automatic rec_a(input int n, input int drop_at, output logic [63:0] ser,
                       output logic [63:0] dn, output logic [63:0] bz);
    ser = '0; dn = '0; bz = '0;
    for (int i = 0; i < n; i++) begin
      ser[i] = serial_a; dn[i] = done_a; bz[i] = busy_a;
      if (i == drop_at) tx_en_a = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic rec_b(input int n, output logic [63:0] ser, output logic [63:0] dn);
    ser = '0; dn = '0;
    for (int i = 0; i < n; i++) begin
      ser[i] = serial_b; dn[i] = done_b;
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios
  task automatic test_reset;
    rst = 1'b1; tx_en_a = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (serial_a !== 1'b1) begin n_fail++; $display("FAIL rst_serial: got %b want 1", serial_a); end
    n_chk++; if (r_en_a !== 1'b0) begin n_fail++; $display("FAIL rst_r_en: got %b want 0", r_en_a); end
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    n_chk++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done_a); end
    n_chk++; if (serial_b !== 1'b1) begin n_fail++; $display("FAIL rst_serial_b: got %b want 1", serial_b); end
    // Word queued and enable high while releasing: no read on the first edge.
    push_a(8'hA5);
    tx_en_a = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (r_en_a !== 1'b0) begin n_fail++; $display("FAIL rel_first_edge_r_en: got %b want 0", r_en_a); end
  endtask

  task automatic test_single_word;
    logic [63:0] ser, dn, bz;
    int w;
    wait_start_a(w);
    rec_a(40, -1, ser, dn, bz);
    n_chk++; if (frame_err(ser, 18'({1'b1, 8'hA5, 1'b0}), 10, 4) != 0)
      begin n_fail++; $display("FAIL a5_bits: got %b want 1101001010 (bit 9..0, x4)", ser[39:0]); end
    n_chk++; if (done_err(dn, 40) != 0)
      begin n_fail++; $display("FAIL a5_done: got %b want only bit 39", dn[39:0]); end
    n_chk++; if (serial_a !== 1'b1 || busy_a !== 1'b0)
      begin n_fail++; $display("FAIL a5_idle_after: serial=%b busy=%b want 1 0", serial_a, busy_a); end
    n_chk++; if (ren_a != 1) begin n_fail++; $display("FAIL a5_r_en_count: got %0d want 1", ren_a); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] ser, dn, bz;
    int w, ren0;
    ren0 = ren_a;
    push_a(8'h00); push_a(8'hFF);
    wait_start_a(w);
    rec_a(40, -1, ser, dn, bz);
    n_chk++; if (frame_err(ser, 18'({1'b1, 8'h00, 1'b0}), 10, 4) != 0)
      begin n_fail++; $display("FAIL b2b_00_bits: got %b want 1000000000 (x4)", ser[39:0]); end
    n_chk++; if (bz[39:0] !== {40{1'b1}}) begin n_fail++; $display("FAIL b2b_busy_f1: got %b", bz[39:0]); end
    // Two idle-high cycles, still busy, then the second start bit.
    n_chk++; if (serial_a !== 1'b1 || busy_a !== 1'b1)
      begin n_fail++; $display("FAIL b2b_gap1: serial=%b busy=%b want 1 1", serial_a, busy_a); end
    @(negedge clk);
    n_chk++; if (serial_a !== 1'b1 || busy_a !== 1'b1)
      begin n_fail++; $display("FAIL b2b_gap2: serial=%b busy=%b want 1 1", serial_a, busy_a); end
    @(negedge clk);
    n_chk++; if (serial_a !== 1'b0) begin n_fail++; $display("FAIL b2b_start2: serial=%b want 0", serial_a); end
    rec_a(40, -1, ser, dn, bz);
    n_chk++; if (frame_err(ser, 18'({1'b1, 8'hFF, 1'b0}), 10, 4) != 0)
      begin n_fail++; $display("FAIL b2b_ff_bits: got %b want 1111111110 (x4)", ser[39:0]); end
    n_chk++; if (bz[39:0] !== {40{1'b1}} || done_err(dn, 40) != 0)
      begin n_fail++; $display("FAIL b2b_busy_done_f2: busy=%b done=%b", bz[39:0], dn[39:0]); end
    n_chk++; if (ren_a - ren0 != 2) begin n_fail++; $display("FAIL b2b_r_en_count: got %0d want 2", ren_a - ren0); end
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: busy=%b want 0", busy_a); end
  endtask

  task automatic test_enable_drop;
    logic [63:0] ser, dn, bz;
    int w, ren0;
    ren0 = ren_a;
    tx_en_a = 1'b1;
    push_a(8'h3C); push_a(8'h99);
    wait_start_a(w);
    rec_a(40, 17, ser, dn, bz);  // samples 16..19 are data bit 3
    n_chk++; if (frame_err(ser, 18'({1'b1, 8'h3C, 1'b0}), 10, 4) != 0)
      begin n_fail++; $display("FAIL drop_3c_bits: got %b want 1001111000 (x4)", ser[39:0]); end
    repeat (20) @(negedge clk);
    n_chk++; if (ren_a - ren0 != 1) begin n_fail++; $display("FAIL drop_no_second_read: got %0d want 1", ren_a - ren0); end
    n_chk++; if (busy_a !== 1'b0 || serial_a !== 1'b1 || empty_a !== 1'b0)
      begin n_fail++; $display("FAIL drop_held: busy=%b serial=%b empty=%b want 0 1 0", busy_a, serial_a, empty_a); end
    tx_en_a = 1'b1;
    wait_start_a(w);
    rec_a(40, -1, ser, dn, bz);
    n_chk++; if (frame_err(ser, 18'({1'b1, 8'h99, 1'b0}), 10, 4) != 0)
      begin n_fail++; $display("FAIL drop_99_bits: got %b want 1100110010 (x4)", ser[39:0]); end
    n_chk++; if (ren_a - ren0 != 2) begin n_fail++; $display("FAIL drop_resume_reads: got %0d want 2", ren_a - ren0); end
  endtask

  task automatic test_empty_fifo;
    int bad_ren = 0, bad_ser = 0, bad_busy = 0;
    tx_en_a = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (r_en_a !== 1'b0) bad_ren++;
      if (serial_a !== 1'b1) bad_ser++;
      if (busy_a !== 1'b0) bad_busy++;
    end
    n_chk++; if (bad_ren != 0) begin n_fail++; $display("FAIL empty_r_en: %0d cycles high, want 0", bad_ren); end
    n_chk++; if (bad_ser != 0) begin n_fail++; $display("FAIL empty_serial: %0d cycles low, want 0", bad_ser); end
    n_chk++; if (bad_busy != 0) begin n_fail++; $display("FAIL empty_busy: %0d cycles busy, want 0", bad_busy); end
  endtask

  task automatic test_mid_frame_reset;
    logic [63:0] ser, dn, bz;
    int w, ren0;
    push_a(8'h81);
    wait_start_a(w);
    repeat (25) @(negedge clk);  // inside data bit 5, which is 0 for 0x81
    n_chk++; if (serial_a !== 1'b0) begin n_fail++; $display("FAIL mrst_bit5: serial=%b want 0", serial_a); end
    rst = 1'b1;
    #1;
    n_chk++; if (serial_a !== 1'b1 || busy_a !== 1'b0 || r_en_a !== 1'b0)
      begin n_fail++; $display("FAIL mrst_async: serial=%b busy=%b r_en=%b want 1 0 0", serial_a, busy_a, r_en_a); end
    push_a(8'h55);
    @(negedge clk);
    rst = 1'b0;
    ren0 = ren_a;
    @(negedge clk);
    n_chk++; if (r_en_a !== 1'b0) begin n_fail++; $display("FAIL mrst_first_edge_r_en: got %b want 0", r_en_a); end
    wait_start_a(w);
    rec_a(40, -1, ser, dn, bz);
    n_chk++; if (frame_err(ser, 18'({1'b1, 8'h55, 1'b0}), 10, 4) != 0)
      begin n_fail++; $display("FAIL mrst_55_bits: got %b want 1010101010 (x4)", ser[39:0]); end
    n_chk++; if (done_err(dn, 40) != 0) begin n_fail++; $display("FAIL mrst_55_done: got %b", dn[39:0]); end
    n_chk++; if (ren_a - ren0 != 1) begin n_fail++; $display("FAIL mrst_reads: got %0d want 1", ren_a - ren0); end
    n_chk++; if (uflow_a !== 1'b0) begin n_fail++; $display("FAIL underflow_a: read strobe while FIFO empty"); end
  endtask

  task automatic test_param_sweep;
    logic [63:0] ser, dn;
    logic [17:0] model;
    int w;
    model = {1'b1, 16'h1234, 1'b0};
    push_b(16'h1234);
    tx_en_b = 1'b1;
    wait_start_b(w);
    rec_b(36, ser, dn);
    n_chk++; if (frame_err(ser, model, 18, 2) != 0)
      begin n_fail++; $display("FAIL sweep_bits: got %b want %b (x2)", ser[35:0], model); end
    n_chk++; if (done_err(dn, 36) != 0) begin n_fail++; $display("FAIL sweep_done: got %b", dn[35:0]); end
    n_chk++; if (serial_b !== 1'b1 || busy_b !== 1'b0 || ren_b != 1)
      begin n_fail++; $display("FAIL sweep_end: serial=%b busy=%b reads=%0d want 1 0 1", serial_b, busy_b, ren_b); end
  endtask

  initial begin
    test_reset;
    test_single_word;
    test_back_to_back;
    test_enable_drop;
    test_empty_fifo;
    test_mid_frame_reset;
    test_param_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
